add_pipe_flags: RTL and testbench

- Parametrised, pipelined successor to the combinational 32-bit flag adder.
- Splits a WIDTH-bit add/subtract into STAGES carry-chained segments, one segment per cycle.
- Produces the sum plus Carry/Zero/Overflow/Sign flags through a valid/ready stream.
- Sits between the datapath operand registers and the ALU result mux, so wide adders close timing at the datapath clock.

---
 rtl/add_pipe_pkg.sv | 55 +++++
 rtl/add_pipe_flags_seg.sv | 33 +++
 rtl/add_pipe_flags.sv | 235 +++++++++++++++++++++++
 tb/tb_add_pipe_flags.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_pipe_pkg.sv
// Purpose : shared constants, flag typedef and parameter legality check for the pipelined flag adder.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   FLAG_C/Z/V/S   bit positions of the carry/zero/overflow/sign flags in flags_t
//   flags_t        4-bit flags vector consumed by the ALU result mux
//   pack_flags()   builds a flags_t from the individual flag bits
//   seg_legal()    true when WIDTH splits evenly into STAGES segments
//   `ADD_PIPE_CHECK_SEG(W, S)  elaboration-time guard built on seg_legal()

`define ADD_PIPE_CHECK_SEG(W, S) \
    if (!add_pipe_pkg::seg_legal((W), (S))) begin : g_seg_illegal \
        $error("add_pipe_flags: WIDTH must be a non-zero multiple of STAGES"); \
    end

package add_pipe_pkg;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_S = 3;
    localparam int unsigned FLAG_W = 4;

    typedef logic [FLAG_W-1:0] flags_t;

    function automatic flags_t pack_flags(
        input logic c,
        input logic z,
        input logic v,
        input logic s
    );
        flags_t f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_Z] = z;
        f[FLAG_V] = v;
        f[FLAG_S] = s;
        return f;
    endfunction

    // Guard the modulo so a zero stage count reports cleanly instead of dividing by zero.
    function automatic logic seg_legal(
        input int unsigned w,
        input int unsigned s
    );
        logic ok;
        ok = 1'b0;
        if (s >= 1) begin
            ok = ((w % s) == 0);
        end
        return ok;
    endfunction

endpackage

// File: rtl/add_pipe_flags_seg.sv
// Purpose : combinational SEG-bit adder slice used once per pipeline stage.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline stage decides when the result is captured.
//
// Ports:
//   a, b   SEG-bit operand slices (b already inverted by the caller for subtraction)
//   ci     carry into the slice
//   sum    SEG-bit slice result
//   co     carry out of the slice MSB
//   c_top  carry into the slice MSB (only the top slice's value matters, for overflow)

module add_seg #(
    parameter int unsigned SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] sum,
    output logic           co,
    output logic           c_top
);

    logic [SEG:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
    assign sum  = full[SEG-1:0];
    assign co   = full[SEG];

    // The carry that entered the top bit is recoverable from that bit's inputs and
    // its sum: s = a ^ b ^ cin  =>  cin = a ^ b ^ s. Works for SEG = 1 as well.
    assign c_top = a[SEG-1] ^ b[SEG-1] ^ sum[SEG-1];

endmodule

// File: rtl/add_pipe_flags.sv
// Purpose : pipelined WIDTH-bit add/subtract with Carry/Zero/Overflow/Sign flags on a valid/ready stream.
// Latency : STAGES enabled cycles from input handshake to out_valid; 1 beat/cycle throughput.
// Backpressure: whole pipe freezes while out_valid & !out_ready; in_ready = !out_valid | out_ready.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake; A, B, c0 (carry-in, add only), sub (1 = A-B)
//   out_valid/out_ready   result handshake; S, C_out (raw carry), Add_Carry (carry, or borrow when
//                         sub=1), Zero, Add_Overflow (signed), Add_Sign
//   ov_clr, ov_sticky     only with ADD_PIPE_STICKY_OV_EN: sticky overflow seen on any output
//                         handshake, cleared by ov_clr (a new set in the same cycle wins)
//
// Stage k adds segment k of A and B' (B' = sub ? ~B : B) with the carry registered by stage k-1.
// The A operand and the result share one register per stage: as each segment is summed its
// operand bits are replaced in place by result bits, so the lower part of acc_q holds finished
// result bits and the upper part holds the not-yet-added A segments. B' is kept shifted so the
// next segment to consume always sits in the low SEG bits.

module add_pipe_flags
    import add_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c0,
    input  logic             sub,
`ifdef ADD_PIPE_STICKY_OV_EN
    input  logic             ov_clr,
    output logic             ov_sticky,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C_out,
    output logic             Add_Carry,
    output logic             Zero,
    output logic             Add_Overflow,
    output logic             Add_Sign
);

    localparam int unsigned SEG  = (STAGES > 0) ? (WIDTH / STAGES) : WIDTH;
    localparam int unsigned LAST = (STAGES > 0) ? (STAGES - 1) : 0;

    `ADD_PIPE_CHECK_SEG(WIDTH, STAGES)

    // ------------------------------------------------------------------
    // Pipeline enable
    // ------------------------------------------------------------------
    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ------------------------------------------------------------------
    // Stage state
    // ------------------------------------------------------------------
    logic             vld_q [STAGES];
    logic             vld_d [STAGES];
    logic [WIDTH-1:0] acc_q [STAGES];   // {A segments still to add, finished result bits}
    logic [WIDTH-1:0] acc_d [STAGES];
    logic [WIDTH-1:0] bsh_q [STAGES];   // B' with already-consumed segments shifted out
    logic [WIDTH-1:0] bsh_d [STAGES];
    logic             cy_q  [STAGES];   // carry out of this stage's segment
    logic             cy_d  [STAGES];
    logic             sub_q [STAGES];   // operation travels with its beat for Add_Carry
    logic             sub_d [STAGES];

    // Flags are computed from the final stage's inputs and captured with it, so every
    // flag output comes straight from a flop.
    flags_t           flags_q;
    flags_t           flags_d;

    // ------------------------------------------------------------------
    // Segment adders, one per stage
    // ------------------------------------------------------------------
    logic [SEG-1:0]   seg_a    [STAGES];
    logic [SEG-1:0]   seg_b    [STAGES];
    logic             seg_ci   [STAGES];
    logic [SEG-1:0]   seg_sum  [STAGES];
    logic             seg_co   [STAGES];
    logic             seg_ctop [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        add_seg #(
            .SEG (SEG)
        ) u_seg (
            .a     (seg_a[k]),
            .b     (seg_b[k]),
            .ci    (seg_ci[k]),
            .sum   (seg_sum[k]),
            .co    (seg_co[k]),
            .c_top (seg_ctop[k])
        );
    end

    // Operand conditioning at the pipe entry.
    logic [WIDTH-1:0] b_in;
    logic             ci_in;

    assign b_in  = sub ? ~B : B;
    // Subtraction forces the +1 of the two's complement; c0 only matters for add.
    assign ci_in = sub | c0;

    // ------------------------------------------------------------------
    // Segment operand selection
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            seg_a[k]  = '0;
            seg_b[k]  = '0;
            seg_ci[k] = 1'b0;
        end

        seg_a[0]  = A[SEG-1:0];
        seg_b[0]  = b_in[SEG-1:0];
        seg_ci[0] = ci_in;

        for (int k = 1; k < STAGES; k++) begin
            seg_a[k]  = acc_q[k-1][k*SEG +: SEG];
            seg_b[k]  = bsh_q[k-1][SEG-1:0];
            seg_ci[k] = cy_q[k-1];
        end
    end

    // ------------------------------------------------------------------
    // Next-state for every stage. Bubbles load like real beats; their data
    // is don't-care because the valid bit travelling with them is 0.
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            vld_d[k] = 1'b0;
            acc_d[k] = '0;
            bsh_d[k] = '0;
            cy_d[k]  = 1'b0;
            sub_d[k] = 1'b0;
        end

        // Stage 0 takes the beat straight from the input ports.
        vld_d[0]            = in_valid;
        acc_d[0]            = A;
        acc_d[0][SEG-1:0]   = seg_sum[0];
        bsh_d[0]            = b_in >> SEG;
        cy_d[0]             = seg_co[0];
        sub_d[0]            = sub;

        for (int k = 1; k < STAGES; k++) begin
            vld_d[k]                 = vld_q[k-1];
            acc_d[k]                 = acc_q[k-1];
            acc_d[k][k*SEG +: SEG]   = seg_sum[k];
            bsh_d[k]                 = bsh_q[k-1] >> SEG;
            cy_d[k]                  = seg_co[k];
            sub_d[k]                 = sub_q[k-1];
        end

        // Overflow: carry into the MSB differs from carry out of the MSB. The top
        // segment's c_top is exactly the carry into bit WIDTH-1.
        flags_d = pack_flags(
            seg_co[LAST] ^ sub_d[LAST],
            (acc_d[LAST] == '0),
            seg_ctop[LAST] ^ seg_co[LAST],
            acc_d[LAST][WIDTH-1]
        );
    end

    // ------------------------------------------------------------------
    // Stage registers. Reset wins over adv so in-flight beats are dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                acc_q[k] <= '0;
                bsh_q[k] <= '0;
                cy_q[k]  <= 1'b0;
                sub_q[k] <= 1'b0;
            end
            flags_q <= '0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= vld_d[k];
                acc_q[k] <= acc_d[k];
                bsh_q[k] <= bsh_d[k];
                cy_q[k]  <= cy_d[k];
                sub_q[k] <= sub_d[k];
            end
            flags_q <= flags_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: everything below is a direct flop output of the final stage.
    // ------------------------------------------------------------------
    assign out_valid    = vld_q[LAST];
    assign S            = acc_q[LAST];
    assign C_out        = cy_q[LAST];
    assign Add_Carry    = flags_q[FLAG_C];
    assign Zero         = flags_q[FLAG_Z];
    assign Add_Overflow = flags_q[FLAG_V];
    assign Add_Sign     = flags_q[FLAG_S];

`ifdef ADD_PIPE_STICKY_OV_EN
    // ------------------------------------------------------------------
    // Sticky overflow: set on an overflowing output handshake, cleared by
    // ov_clr; a set in the same cycle takes priority over the clear.
    // ------------------------------------------------------------------
    logic ov_sticky_q;
    logic ov_sticky_d;

    always_comb begin
        ov_sticky_d = ov_sticky_q;
        if (out_valid && out_ready && flags_q[FLAG_V]) begin
            ov_sticky_d = 1'b1;
        end else if (ov_clr) begin
            ov_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ov_sticky_q <= 1'b0;
        end else begin
            ov_sticky_q <= ov_sticky_d;
        end
    end

    assign ov_sticky = ov_sticky_q;
`endif

endmodule

// File: tb/tb_add_pipe_flags.sv
// Purpose : self-checking bench for add_pipe_flags (WIDTH=32, STAGES=4) using directed vectors.
// Latency : checks that every isolated beat returns exactly STAGES cycles after acceptance.
// Backpressure: exercises an out_ready stall mid-stream and a reset with beats in flight.

module tb_add_pipe_flags;

    localparam int W  = 32;
    localparam int ST = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          c0;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  S;
    logic          C_out;
    logic          Add_Carry;
    logic          Zero;
    logic          Add_Overflow;
    logic          Add_Sign;
`ifdef ADD_PIPE_STICKY_OV_EN
    logic          ov_clr;
    logic          ov_sticky;
`endif

    always #5 clk = ~clk;

    add_pipe_flags #(
        .WIDTH  (W),
        .STAGES (ST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .A            (A),
        .B            (B),
        .c0           (c0),
        .sub          (sub),
`ifdef ADD_PIPE_STICKY_OV_EN
        .ov_clr       (ov_clr),
        .ov_sticky    (ov_sticky),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .S            (S),
        .C_out        (C_out),
        .Add_Carry    (Add_Carry),
        .Zero         (Zero),
        .Add_Overflow (Add_Overflow),
        .Add_Sign     (Add_Sign)
    );

    // fl = {C_out, Add_Carry, Zero, Add_Overflow, Add_Sign}
    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c0;
        logic         sub;
        logic [W-1:0] s;
        logic [4:0]   fl;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [4:0] flags_now();
        return {C_out, Add_Carry, Zero, Add_Overflow, Add_Sign};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one beat into an empty pipe, wait (bounded) for its result, check it, consume it.
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        A        = v.a;
        B        = v.b;
        c0       = v.c0;
        sub      = v.sub;
        in_valid = 1'b1;
        #1;
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(ST));
        check({tag, " S"}, 64'(S), 64'(v.s));
        check({tag, " flags"}, 64'(flags_now()), 64'(v.fl));
        tick();
    endtask

    initial begin
        int   sent;
        int   got;
        int   seen;
        logic [W-1:0] held;

        vecs[0] = '{32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 32'h8000_0000, 5'b00011};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 5'b11100};
        vecs[2] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 5'b01001};
        vecs[3] = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 5'b10100};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 5'b10010};
        vecs[5] = '{32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0001_0001, 5'b00000};
        vecs[6] = '{32'h0000_0003, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_0002, 5'b10000};
        vecs[7] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 5'b00011};
        vecs[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 5'b11001};
        vecs[9] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 5'b00100};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        c0        = 1'b0;
        sub       = 1'b0;
`ifdef ADD_PIPE_STICKY_OV_EN
        ov_clr    = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst S", 64'(S), 64'd0);
        check("rst flags", 64'(flags_now()), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);
`ifdef ADD_PIPE_STICKY_OV_EN
        check("rst ov_sticky", 64'(ov_sticky), 64'd0);
`endif

        // Directed single-beat vectors
        out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

`ifdef ADD_PIPE_STICKY_OV_EN
        check("sticky after ov beats", 64'(ov_sticky), 64'd1);
        ov_clr = 1'b1;
        tick();
        ov_clr = 1'b0;
        check("sticky cleared", 64'(ov_sticky), 64'd0);
        run_vec(vecs[1], "sticky_noov");
        check("sticky stays clear", 64'(ov_sticky), 64'd0);
        run_vec(vecs[0], "sticky_ov");
        check("sticky set", 64'(ov_sticky), 64'd1);
        run_vec(vecs[5], "sticky_hold");
        check("sticky holds", 64'(ov_sticky), 64'd1);
`endif

        // Back-to-back stream of 8 beats with a 3-cycle output stall
        sent = 0;
        got  = 0;
        held = '0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            in_valid  = (sent < 8);
            A         = W'(sent);
            B         = W'(sent);
            c0        = 1'b1;
            sub       = 1'b0;
            out_ready = !(cyc >= 6 && cyc <= 8);
            #2;
            if (!out_ready && out_valid) begin
                check($sformatf("stall%0d in_ready", cyc), 64'(in_ready), 64'd0);
                if (cyc == 6) held = S;
                else check($sformatf("stall%0d S held", cyc), 64'(S), 64'(held));
            end
            if (out_valid && out_ready) begin
                check($sformatf("stream beat%0d S", got), 64'(S), 64'(W'(2 * got + 1)));
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream results", 64'(got), 64'd8);
        check("stream sent", 64'(sent), 64'd8);
        seen = 0;
        repeat (6) begin
            tick();
            if (out_valid) seen++;
        end
        check("stream no duplicate", 64'(seen), 64'd0);

        // Reset with 3 beats in flight
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            A        = W'(100 + i);
            B        = W'(1);
            c0       = 1'b0;
            sub      = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst S", 64'(S), 64'd0);
        check("midrst flags", 64'(flags_now()), 64'd0);
        check("midrst in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (8) begin
            tick();
            if (out_valid) seen++;
        end
        check("midrst no stale result", 64'(seen), 64'd0);
        run_vec('{32'h0000_0007, 32'h0000_0009, 1'b0, 1'b0, 32'h0000_0010, 5'b00000}, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
